irq_arbiter: RTL and testbench
==============================

# irq_arbiter

Bus-mapped interrupt arbiter that merges up to NUM_SRC peripheral interrupt requests (timer, IR transmitter, mouse, and later additions) onto a single processor interrupt line. It latches requests into a pending register, applies a software mask, and grants one source at a time. It then completes the raise/ack handshake with the processor and forwards the acknowledge to the granted peripheral. Software reads the granted source ID from a vector register on the shared 8-bit bus.

## Interface
- NUM_SRC, 4: number of request sources, 1..8
- BASE_ADDR, 8'hE0: bus base address; registers at BASE_ADDR+0..+2
- CLK  in  1  system clock, all logic on rising edge
- RESET  in  1  asynchronous, active-low reset
- BUS_ADDR  in  8  shared bus address
- BUS_DATA  inout  8  shared bus data; driven only during an arbiter read, else high-Z
- BUS_WE  in  1  bus write enable
- SRC_RAISE  in  NUM_SRC  per-source request, held high by the peripheral until acknowledged
- SRC_ACK  out  NUM_SRC  per-source one-cycle acknowledge pulse
- CPU_IRQ_RAISE  out  1  request to processor interrupt input
- CPU_IRQ_ACK  in  1  processor acknowledge

## Operation
- Registers:
  - MASK (+0, RW): bit i = 1 enables source i; reset 8'hFF.
  - PENDING (+1, R, write-1-to-clear): reset 0.
  - VECTOR (+2, R): bit7 = grant valid, bits 2:0 = granted source ID; reset 0.
  - Bits at or above NUM_SRC read 0 and ignore writes.
- Pending: bit i is set every cycle SRC_RAISE[i] is high.
  - When a set and a W1C write hit the same bit in one cycle, set wins.
  - When a set and the grant-completion clear hit the same bit in one cycle, the clear wins.
- FSM states: IDLE, RAISE, ACK.
  - IDLE: if (PENDING & MASK) is nonzero, select a source, latch it into VECTOR with valid=1, and go to RAISE.
  - RAISE: CPU_IRQ_RAISE=1. On CPU_IRQ_ACK=1, go to ACK. A grant is never retracted: changing MASK or writing W1C on the granted bit does not abort it.
  - ACK: CPU_IRQ_RAISE=0, SRC_ACK[grant]=1 for exactly this cycle, PENDING[grant] cleared, VECTOR valid cleared. Unconditionally return to IDLE.
- CPU_IRQ_ACK is ignored outside RAISE.
- Bus reads have one-cycle latency:
  - An address match with BUS_WE=0 in cycle n drives BUS_DATA with the register value during cycle n+1.
  - A bus write takes effect at the end of the cycle it is presented.
- Reset (any time, including mid-handshake): FSM returns to IDLE, all outputs return to 0, BUS_DATA goes high-Z, registers take their reset values. No SRC_ACK is issued for an interrupted grant.

## Timing
- SRC_RAISE first high in cycle 0: PENDING set at end of cycle 0, grant at end of cycle 1, CPU_IRQ_RAISE high from cycle 2.
- CPU_IRQ_ACK high in cycle k, while in RAISE:
  - CPU_IRQ_RAISE low and SRC_ACK pulse in cycle k+1.
  - IDLE in cycle k+2.
  - Next CPU_IRQ_RAISE no earlier than cycle k+3, so CPU_IRQ_RAISE is low for at least 2 cycles between grants.
- The peripheral drops SRC_RAISE one cycle after SRC_ACK. Because the clear wins during ACK, no spurious re-pend occurs.

## Configuration
- IRQ_ARB_RR_EN defined: round-robin selection. The search starts at (last grant + 1) mod NUM_SRC; the pointer resets to 0 and updates on entry to ACK.
- IRQ_ARB_RR_EN undefined: fixed priority, lowest index wins. No pointer register is present.

## Structure
- Package irq_arb_pkg holds:
  - FSM state enum
  - register offset constants: MASK=0, PENDING=1, VECTOR=2
  - VECTOR valid-bit position
- Sub-module irq_arb_picker: purely combinational. Inputs are the masked request vector and the start pointer; outputs are the one-hot/ID grant and a found flag. It holds the fixed/round-robin selection logic.
- The bus interface, registers and FSM live in the top module.

## Test plan
- Single source: SRC_RAISE[1] high at cycle 0 → CPU_IRQ_RAISE high at cycle 2, VECTOR reads 8'h81. CPU_IRQ_ACK at cycle 5 → SRC_ACK=4'b0010 for one cycle at cycle 6, PENDING reads 0.
- Masking: MASK=8'hFD, SRC_RAISE[1] high → CPU_IRQ_RAISE stays 0 and PENDING reads 8'h02. Write MASK=8'hFF → raise within 2 cycles.
- Simultaneous requests 4'b0101, three back-to-back acks:
  - fixed priority: grants 0, 2, 0 while both are held;
  - with IRQ_ARB_RR_EN: grants 0, 2, 0 strictly alternating, never the same source twice while the other is pending.
- W1C: write 8'h04 to PENDING while SRC_RAISE[2] is still high → bit stays set. Write after the source drops → PENDING reads 0.
- Reset mid-handshake: RESET low during RAISE → CPU_IRQ_RAISE=0, SRC_ACK=0, VECTOR=0, MASK=8'hFF. After release with no requests, no raise occurs.

Source files
------------

// File: rtl/irq_arb_pkg.sv
// irq_arbiter shared types: FSM states,
// register offsets and VECTOR layout.
package irq_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RAISE,
    ST_ACK
  } state_t;

  localparam logic [1:0] OFF_MASK    = 2'd0;
  localparam logic [1:0] OFF_PENDING = 2'd1;
  localparam logic [1:0] OFF_VECTOR  = 2'd2;

  localparam int VEC_VALID_BIT = 7;

endpackage

// File: rtl/irq_arb_if.sv
// irq_arbiter bus-side and interrupt
// handshake signals (bus data is a port).
interface irq_arb_if #(
  parameter int NUM_SRC = 4
) ();

  logic [7:0]         bus_addr;
  logic               bus_we;
  logic [NUM_SRC-1:0] src_raise;
  logic [NUM_SRC-1:0] src_ack;
  logic               cpu_irq_raise;
  logic               cpu_irq_ack;

  modport master (
    output bus_addr,
    output bus_we,
    output src_raise,
    output cpu_irq_ack,
    input  src_ack,
    input  cpu_irq_raise
  );

  modport slave (
    input  bus_addr,
    input  bus_we,
    input  src_raise,
    input  cpu_irq_ack,
    output src_ack,
    output cpu_irq_raise
  );

endinterface

// File: rtl/irq_arb_picker.sv
// Combinational source selector: fixed
// priority, or round-robin with IRQ_ARB_RR_EN.
module irq_arb_picker
  import irq_arb_pkg::*;
#(
  parameter int NUM_SRC = 4
) (
  input  logic [NUM_SRC-1:0] req,
  input  logic [2:0]         start,
  output logic [NUM_SRC-1:0] grant_oh,
  output logic [2:0]         grant_id,
  output logic               found
);

  logic [2:0] base;
  logic [7:0] req8;
  logic [7:0] oh8;
  logic [2:0] idx;

`ifdef IRQ_ARB_RR_EN
  assign base = start;
`else
  logic unused_start;
  assign base = 3'd0;
  assign unused_start = ^start;
`endif

  assign req8 = 8'(req);

  always_comb begin
    grant_id = 3'd0;
    found    = 1'b0;
    idx      = 3'd0;
    for (int i = 0; i < NUM_SRC; i++) begin
      idx = 3'((32'(base) + i) % NUM_SRC);
      if (!found && req8[idx]) begin
        found    = 1'b1;
        grant_id = idx;
      end
    end
  end

  assign oh8      = found ? (8'd1 << grant_id) : 8'd0;
  assign grant_oh = NUM_SRC'(oh8);

endmodule

// File: rtl/irq_arbiter.sv
// Bus-mapped interrupt arbiter: pending/mask regs,
// grant FSM. IRQ_ARB_RR_EN selects round-robin.
module irq_arbiter
  import irq_arb_pkg::*;
#(
  parameter int         NUM_SRC   = 4,
  parameter logic [7:0] BASE_ADDR = 8'hE0
) (
  input  logic       clk,
  input  logic       reset,
  inout  wire  [7:0] bus_data,
  irq_arb_if.slave   bus
);

  state_t             state;
  logic [NUM_SRC-1:0] mask;
  logic [NUM_SRC-1:0] pending;
  logic [NUM_SRC-1:0] req;
  logic [NUM_SRC-1:0] w1c;
  logic [NUM_SRC-1:0] gnt_oh;
  logic [NUM_SRC-1:0] pick_oh;
  logic [2:0]         pick_id;
  logic               pick_found;
  logic [2:0]         vec_id;
  logic               vec_valid;
  logic [2:0]         ptr;
  logic [7:0]         off;
  logic [1:0]         sel;
  logic               hit;
  logic               wr;
  logic [7:0]         reg_val;
  logic [7:0]         rd_data;
  logic               rd_en;

  assign off = bus.bus_addr - BASE_ADDR;
  assign sel = off[1:0];
  assign hit = off < 8'd3;
  assign wr  = hit && bus.bus_we;
  assign w1c = (wr && sel == OFF_PENDING)
             ? NUM_SRC'(bus_data) : '0;
  assign req = pending & mask;

  always_comb begin
    reg_val = 8'd0;
    unique case (1'b1)
      (sel == OFF_MASK):    reg_val = 8'(mask);
      (sel == OFF_PENDING): reg_val = 8'(pending);
      (sel == OFF_VECTOR): begin
        reg_val[VEC_VALID_BIT] = vec_valid;
        reg_val[2:0]           = vec_id;
      end
      default:              reg_val = 8'd0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_en   <= 1'b0;
      rd_data <= 8'd0;
    end else begin
      rd_en   <= hit && !bus.bus_we;
      rd_data <= reg_val;
    end
  end

  assign bus_data = rd_en ? rd_data : 8'hzz;

  // A new request beats W1C; the grant clear beats a new request.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mask    <= '1;
      pending <= '0;
    end else begin
      if (wr && sel == OFF_MASK)
        mask <= NUM_SRC'(bus_data);
      pending <= ((pending & ~w1c) | bus.src_raise)
               & ~bus.src_ack;
    end
  end

`ifdef IRQ_ARB_RR_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      ptr <= 3'd0;
    else if (state == ST_RAISE && bus.cpu_irq_ack)
      ptr <= (vec_id == 3'(NUM_SRC - 1))
           ? 3'd0 : vec_id + 3'd1;
  end
`else
  assign ptr = 3'd0;
`endif

  irq_arb_picker #(
    .NUM_SRC (NUM_SRC)
  ) u_picker (
    .req      (req),
    .start    (ptr),
    .grant_oh (pick_oh),
    .grant_id (pick_id),
    .found    (pick_found)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state             <= ST_IDLE;
      vec_valid         <= 1'b0;
      vec_id            <= 3'd0;
      gnt_oh            <= '0;
      bus.cpu_irq_raise <= 1'b0;
      bus.src_ack       <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (pick_found) begin
            state             <= ST_RAISE;
            vec_valid         <= 1'b1;
            vec_id            <= pick_id;
            gnt_oh            <= pick_oh;
            bus.cpu_irq_raise <= 1'b1;
          end
        end
        ST_RAISE: begin
          if (bus.cpu_irq_ack) begin
            state             <= ST_ACK;
            bus.cpu_irq_raise <= 1'b0;
            bus.src_ack       <= gnt_oh;
          end
        end
        ST_ACK: begin
          state       <= ST_IDLE;
          vec_valid   <= 1'b0;
          bus.src_ack <= '0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_irq_arbiter.sv
// Self-checking bench for irq_arbiter; the
// expectations hold with or without IRQ_ARB_RR_EN.
module tb_irq_arbiter;
  import irq_arb_pkg::*;

  localparam int         N    = 4;
  localparam logic [7:0] BASE = 8'hE0;

  logic         clk    = 1'b0;
  logic         reset  = 1'b0;
  logic         drv_en = 1'b0;
  logic [7:0]   drv    = 8'd0;
  wire  [7:0]   bus_data;
  int           tests_run    = 0;
  int           tests_failed = 0;
  int           exp_q[$];
  logic [7:0]   src_bits;
  logic [7:0]   d;
  logic [N-1:0] want_oh;
  int           id;
  int           waited;
  logic         seen;

  irq_arb_if #(.NUM_SRC(N)) bus ();

  irq_arbiter #(
    .NUM_SRC   (N),
    .BASE_ADDR (BASE)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .bus_data (bus_data),
    .bus      (bus)
  );

  assign bus_data = drv_en ? drv : 8'hzz;

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: time=%0t limit=500000", $time);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_rd(input logic [1:0] o,
                        output logic [7:0] v);
    bus.bus_addr = BASE + 8'(o);
    bus.bus_we   = 1'b0;
    tick();
    v = bus_data;
    bus.bus_addr = 8'h00;
  endtask

  task automatic bus_wr(input logic [1:0] o,
                        input logic [7:0] v);
    bus.bus_addr = BASE + 8'(o);
    bus.bus_we   = 1'b1;
    drv          = v;
    drv_en       = 1'b1;
    tick();
    bus.bus_we   = 1'b0;
    drv_en       = 1'b0;
    bus.bus_addr = 8'h00;
  endtask

  task automatic wait_raise();
    waited = 0;
    while (bus.cpu_irq_raise !== 1'b1 && waited < 10) begin
      tick();
      waited++;
    end
  endtask

  task automatic test_reset();
    reset           = 1'b0;
    bus.src_raise   = '0;
    bus.cpu_irq_ack = 1'b0;
    bus.bus_addr    = 8'h00;
    bus.bus_we      = 1'b0;
    repeat (3) tick();
    tests_run++;
    if (bus.cpu_irq_raise !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_raise: got %b want 0", bus.cpu_irq_raise);
    end
    tests_run++;
    if (bus.src_ack !== '0) begin
      tests_failed++;
      $display("FAIL reset_ack: got %b want 0", bus.src_ack);
    end
    reset = 1'b1;
    tick();
    bus_rd(OFF_MASK, d);
    tests_run++;
    if (d !== src_bits) begin
      tests_failed++;
      $display("FAIL reset_mask: got %h want %h", d, src_bits);
    end
    bus_rd(OFF_PENDING, d);
    tests_run++;
    if (d !== 8'h00) begin
      tests_failed++;
      $display("FAIL reset_pending: got %h want 00", d);
    end
    bus_rd(OFF_VECTOR, d);
    tests_run++;
    if (d !== 8'h00) begin
      tests_failed++;
      $display("FAIL reset_vector: got %h want 00", d);
    end
  endtask

  task automatic test_back_to_back();
    exp_q.push_back(0);
    exp_q.push_back(2);
    exp_q.push_back(0);
    exp_q.push_back(2);
    bus.src_raise = 4'b0101;
    for (int g = 0; g < 4; g++) begin
      wait_raise();
      tests_run++;
      if (bus.cpu_irq_raise !== 1'b1) begin
        tests_failed++;
        $display("FAIL b2b_raise%0d: got %b want 1", g, bus.cpu_irq_raise);
      end
      id      = exp_q.pop_front();
      want_oh = N'(1 << id);
      bus_rd(OFF_VECTOR, d);
      tests_run++;
      if (d !== (8'h80 | 8'(id))) begin
        tests_failed++;
        $display("FAIL b2b_vector%0d: got %h want %h", g, d, 8'h80 | 8'(id));
      end
      bus.cpu_irq_ack = 1'b1;
      tick();
      bus.cpu_irq_ack = 1'b0;
      tests_run++;
      if (bus.src_ack !== want_oh) begin
        tests_failed++;
        $display("FAIL b2b_ack%0d: got %b want %b", g, bus.src_ack, want_oh);
      end
      tick();
      tests_run++;
      if (bus.src_ack !== '0 || bus.cpu_irq_raise !== 1'b0) begin
        tests_failed++;
        $display("FAIL b2b_gap%0d: ack=%b raise=%b want 0/0", g, bus.src_ack, bus.cpu_irq_raise);
      end
      if (g == 2) bus.src_raise = '0;
    end
    tick();
    bus_rd(OFF_PENDING, d);
    tests_run++;
    if (d !== 8'h00) begin
      tests_failed++;
      $display("FAIL b2b_pending: got %h want 00", d);
    end
  endtask

  task automatic test_single();
    bus.src_raise = 4'b0010;
    tick();
    tests_run++;
    if (bus.cpu_irq_raise !== 1'b0) begin
      tests_failed++;
      $display("FAIL single_early: got %b want 0", bus.cpu_irq_raise);
    end
    tick();
    tests_run++;
    if (bus.cpu_irq_raise !== 1'b1) begin
      tests_failed++;
      $display("FAIL single_raise: got %b want 1", bus.cpu_irq_raise);
    end
    bus_rd(OFF_VECTOR, d);
    tests_run++;
    if (d !== 8'h81) begin
      tests_failed++;
      $display("FAIL single_vector: got %h want 81", d);
    end
    tick();
    tick();
    bus.cpu_irq_ack = 1'b1;
    exp_q.push_back(1);
    tick();
    bus.cpu_irq_ack = 1'b0;
    id      = exp_q.pop_front();
    want_oh = N'(1 << id);
    tests_run++;
    if (bus.src_ack !== want_oh || bus.cpu_irq_raise !== 1'b0) begin
      tests_failed++;
      $display("FAIL single_ack: ack=%b raise=%b want %b/0", bus.src_ack, bus.cpu_irq_raise, want_oh);
    end
    tick();
    tests_run++;
    if (bus.src_ack !== '0) begin
      tests_failed++;
      $display("FAIL single_pulse: got %b want 0", bus.src_ack);
    end
    bus.src_raise = '0;
    tick();
    tick();
    tests_run++;
    if (bus.cpu_irq_raise !== 1'b0) begin
      tests_failed++;
      $display("FAIL single_repend: got %b want 0", bus.cpu_irq_raise);
    end
    bus_rd(OFF_PENDING, d);
    tests_run++;
    if (d !== 8'h00) begin
      tests_failed++;
      $display("FAIL single_pending: got %h want 00", d);
    end
    bus_rd(OFF_VECTOR, d);
    tests_run++;
    if (d[7] !== 1'b0) begin
      tests_failed++;
      $display("FAIL single_valid: got %b want 0", d[7]);
    end
  endtask

  task automatic test_mask();
    bus_wr(OFF_MASK, 8'hFD);
    bus_rd(OFF_MASK, d);
    tests_run++;
    if (d !== (8'hFD & src_bits)) begin
      tests_failed++;
      $display("FAIL mask_read: got %h want %h", d, 8'hFD & src_bits);
    end
    bus.src_raise   = 4'b0010;
    bus.cpu_irq_ack = 1'b1;
    repeat (4) tick();
    bus.cpu_irq_ack = 1'b0;
    tests_run++;
    if (bus.cpu_irq_raise !== 1'b0 || bus.src_ack !== '0) begin
      tests_failed++;
      $display("FAIL mask_block: raise=%b ack=%b want 0/0", bus.cpu_irq_raise, bus.src_ack);
    end
    bus_rd(OFF_PENDING, d);
    tests_run++;
    if (d !== 8'h02) begin
      tests_failed++;
      $display("FAIL mask_pending: got %h want 02", d);
    end
    bus_wr(OFF_MASK, 8'hFF);
    tick();
    tests_run++;
    if (bus.cpu_irq_raise !== 1'b1) begin
      tests_failed++;
      $display("FAIL mask_release: got %b want 1", bus.cpu_irq_raise);
    end
    bus.cpu_irq_ack = 1'b1;
    exp_q.push_back(1);
    tick();
    bus.cpu_irq_ack = 1'b0;
    id      = exp_q.pop_front();
    want_oh = N'(1 << id);
    tests_run++;
    if (bus.src_ack !== want_oh) begin
      tests_failed++;
      $display("FAIL mask_ack: got %b want %b", bus.src_ack, want_oh);
    end
    tick();
    bus.src_raise = '0;
    repeat (3) tick();
  endtask

  task automatic test_w1c();
    bus_wr(OFF_MASK, 8'hFB);
    bus.src_raise = 4'b0100;
    tick();
    tick();
    bus_wr(OFF_PENDING, 8'h04);
    bus_rd(OFF_PENDING, d);
    tests_run++;
    if (d !== 8'h04) begin
      tests_failed++;
      $display("FAIL w1c_set_wins: got %h want 04", d);
    end
    bus.src_raise = '0;
    tick();
    bus_wr(OFF_PENDING, 8'h04);
    bus_rd(OFF_PENDING, d);
    tests_run++;
    if (d !== 8'h00) begin
      tests_failed++;
      $display("FAIL w1c_clear: got %h want 00", d);
    end
    bus_wr(OFF_MASK, 8'hFF);
    repeat (3) tick();
    tests_run++;
    if (bus.cpu_irq_raise !== 1'b0) begin
      tests_failed++;
      $display("FAIL w1c_no_raise: got %b want 0", bus.cpu_irq_raise);
    end
  endtask

  task automatic test_reset_mid();
    bus_wr(OFF_MASK, 8'h08);
    bus.src_raise = 4'b1000;
    wait_raise();
    tests_run++;
    if (bus.cpu_irq_raise !== 1'b1) begin
      tests_failed++;
      $display("FAIL rst_pre: got %b want 1", bus.cpu_irq_raise);
    end
    reset = 1'b0;
    #1;
    tests_run++;
    if (bus.cpu_irq_raise !== 1'b0 || bus.src_ack !== '0) begin
      tests_failed++;
      $display("FAIL rst_async: raise=%b ack=%b want 0/0", bus.cpu_irq_raise, bus.src_ack);
    end
    bus.src_raise   = '0;
    bus.cpu_irq_ack = 1'b1;
    tick();
    tick();
    bus.cpu_irq_ack = 1'b0;
    reset = 1'b1;
    tick();
    bus_rd(OFF_VECTOR, d);
    tests_run++;
    if (d !== 8'h00) begin
      tests_failed++;
      $display("FAIL rst_vector: got %h want 00", d);
    end
    bus_rd(OFF_MASK, d);
    tests_run++;
    if (d !== src_bits) begin
      tests_failed++;
      $display("FAIL rst_mask: got %h want %h", d, src_bits);
    end
    seen = 1'b0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (bus.cpu_irq_raise !== 1'b0 || bus.src_ack !== '0) seen = 1'b1;
    end
    tests_run++;
    if (seen !== 1'b0) begin
      tests_failed++;
      $display("FAIL rst_quiet: activity=%b want 0", seen);
    end
  endtask

  initial begin
    src_bits = (8'd1 << N) - 8'd1;
    test_reset();
    test_back_to_back();
    test_single();
    test_mask();
    test_w1c();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
